// File: rtl/vga_timing_gen_if.sv
// Pixel-timing bundle between the VGA timing generator and its consumers.
// The consumer supplies the pixel enable; the generator drives everything else.
interface vga_timing_gen_if;
  logic        pix_ce;
  logic [9:0]  CounterX;
  logic [9:0]  CounterY;
  logic        inDisplayArea;
  logic        vga_h_sync;
  logic        vga_v_sync;
  logic        frame_start;
  logic [15:0] frame_count;

  modport master (
    input  pix_ce,
    output CounterX, CounterY, inDisplayArea, vga_h_sync, vga_v_sync,
           frame_start, frame_count
  );

  modport slave (
    output pix_ce,
    input  CounterX, CounterY, inDisplayArea, vga_h_sync, vga_v_sync,
           frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pix_ce-qualified X/Y counters, display-area flag, frame pulse/count,
// and sync pulses delayed SYNC_DELAY pixel stages to match a downstream colour pipeline.
module vga_timing_gen #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int SYNC_ACT_LOW = 1,
  parameter int SYNC_DELAY   = 1
) (
  input logic              clk,
  input logic              reset,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic       ACT_LOW = (SYNC_ACT_LOW != 0);

  logic       started;
  logic       wrapX, wrapY;
  logic [9:0] nextX, nextY;
  logic       hRaw, vRaw;
  logic       hOut, vOut;

  // Next raster position; the first enabled edge after reset only presents (0,0).
  always_comb begin
    wrapX = (vga.CounterX == H_LAST);
    wrapY = (vga.CounterY == V_LAST);
    nextX = wrapX ? 10'd0 : vga.CounterX + 10'd1;
    nextY = vga.CounterY;
    if (wrapX) nextY = wrapY ? 10'd0 : vga.CounterY + 10'd1;
    if (!started) begin
      nextX = 10'd0;
      nextY = 10'd0;
    end
  end

  // Flags are decoded from the next position so they register in step with the counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      started           <= 1'b0;
      vga.CounterX      <= 10'd0;
      vga.CounterY      <= 10'd0;
      vga.inDisplayArea <= 1'b0;
      vga.frame_start   <= 1'b0;
      vga.frame_count   <= 16'd0;
      hRaw              <= 1'b0;
      vRaw              <= 1'b0;
    end else begin
      vga.frame_start <= 1'b0;
      if (vga.pix_ce) begin
        started           <= 1'b1;
        vga.CounterX      <= nextX;
        vga.CounterY      <= nextY;
        vga.inDisplayArea <= (nextX < H_ACT) && (nextY < V_ACT);
        vga.frame_start   <= (nextX == 10'd0) && (nextY == 10'd0);
        hRaw              <= (nextX >= H_SS) && (nextX <= H_SE);
        vRaw              <= (nextY >= V_SS) && (nextY <= V_SE);
        if (started && wrapX && wrapY) vga.frame_count <= vga.frame_count + 16'd1;
      end
    end
  end

  generate
    if (SYNC_DELAY == 0) begin : gNoDelay
      assign hOut = hRaw;
      assign vOut = vRaw;
    end else begin : gDelay
      logic [SYNC_DELAY-1:0] hDly, vDly;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          hDly <= '0;
          vDly <= '0;
        end else if (vga.pix_ce) begin
          hDly <= (hDly << 1) | SYNC_DELAY'(hRaw);
          vDly <= (vDly << 1) | SYNC_DELAY'(vRaw);
        end
      end

      assign hOut = hDly[SYNC_DELAY-1];
      assign vOut = vDly[SYNC_DELAY-1];
    end
  endgenerate

  assign vga.vga_h_sync = hOut ^ ACT_LOW;
  assign vga.vga_v_sync = vOut ^ ACT_LOW;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing instance for line-level behaviour, a tiny raster
// instance (16x9, active-high syncs, no delay) for frame-level behaviour.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  vga_timing_gen_if ifA ();
  vga_timing_gen_if ifB ();

  vga_timing_gen dutA (
    .clk   (clk),
    .reset (reset),
    .vga   (ifA.master)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_ACT_LOW(0), .SYNC_DELAY(0)
  ) dutB (
    .clk   (clk),
    .reset (reset),
    .vga   (ifB.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic prevS, prevH;
    int   nFall, fallX, fallCyc, period, width, lowRun, vLow, nFs, riseX;

    reset = 1'b1;
    ifA.pix_ce = 1'b0;
    ifB.pix_ce = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_x",     32'(ifA.CounterX), 32'd0);
    check("rst_y",     32'(ifA.CounterY), 32'd0);
    check("rst_fc",    32'(ifA.frame_count), 32'd0);
    check("rst_fs",    32'(ifA.frame_start), 32'd0);
    check("rst_disp",  32'(ifA.inDisplayArea), 32'd0);
    check("rst_hs_lo", 32'(ifA.vga_h_sync), 32'd1);
    check("rst_vs_lo", 32'(ifA.vga_v_sync), 32'd1);
    check("rst_hs_hi", 32'(ifB.vga_h_sync), 32'd0);
    check("rst_vs_hi", 32'(ifB.vga_v_sync), 32'd0);

    // Released but not enabled: everything holds.
    reset = 1'b0;
    @(negedge clk);
    check("hold_fs", 32'(ifA.frame_start), 32'd0);
    check("hold_x",  32'(ifA.CounterX), 32'd0);

    ifA.pix_ce = 1'b1;
    @(negedge clk);
    check("first_x",    32'(ifA.CounterX), 32'd0);
    check("first_y",    32'(ifA.CounterY), 32'd0);
    check("first_fs",   32'(ifA.frame_start), 32'd1);
    check("first_disp", 32'(ifA.inDisplayArea), 32'd1);
    @(negedge clk);
    check("second_x",  32'(ifA.CounterX), 32'd1);
    check("second_fs", 32'(ifA.frame_start), 32'd0);
    repeat (638) @(negedge clk);
    check("x639",      32'(ifA.CounterX), 32'd639);
    check("disp_x639", 32'(ifA.inDisplayArea), 32'd1);
    @(negedge clk);
    check("x640",      32'(ifA.CounterX), 32'd640);
    check("disp_x640", 32'(ifA.inDisplayArea), 32'd0);

    // Free run: hsync shape over two lines, vsync must stay inactive.
    prevS = ifA.vga_h_sync; nFall = 0; fallX = -1; fallCyc = 0; period = -1;
    width = -1; lowRun = 0; vLow = 0;
    for (int i = 0; i < 1700; i++) begin
      @(negedge clk);
      if (ifA.vga_v_sync !== 1'b1) vLow++;
      if (prevS && !ifA.vga_h_sync) begin
        nFall++;
        if (nFall == 1) begin fallX = int'(ifA.CounterX); fallCyc = i; end
        else if (nFall == 2) period = i - fallCyc;
      end
      if (!ifA.vga_h_sync) lowRun++;
      else begin
        if (!prevS && nFall > 0 && width < 0) width = lowRun;
        lowRun = 0;
      end
      prevS = ifA.vga_h_sync;
    end
    check("hs_fall_x",  32'(fallX), 32'd657);
    check("hs_width",   32'(width), 32'd96);
    check("hs_period",  32'(period), 32'd800);
    check("vs_idle",    32'(vLow), 32'd0);
    check("run_x",      32'(ifA.CounterX), 32'd740);
    check("run_y",      32'(ifA.CounterY), 32'd2);

    // Half-rate pixel enable: counters advance every other clock, pulse doubles.
    ifA.pix_ce = 1'b0;
    prevS = ifA.vga_h_sync; nFall = 0; width = -1; lowRun = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (prevS && !ifA.vga_h_sync) nFall++;
      if (!ifA.vga_h_sync) lowRun++;
      else begin
        if (!prevS && nFall > 0 && width < 0) width = lowRun;
        lowRun = 0;
      end
      prevS = ifA.vga_h_sync;
      ifA.pix_ce = ~ifA.pix_ce;
    end
    check("half_hs_width", 32'(width), 32'd192);
    check("half_x",        32'(ifA.CounterX), 32'd140);
    check("half_y",        32'(ifA.CounterY), 32'd4);

    // Small raster: H_TOTAL 16, V_TOTAL 9, 144 clocks per frame.
    ifB.pix_ce = 1'b1;
    @(negedge clk);
    check("b_first_fs",   32'(ifB.frame_start), 32'd1);
    check("b_first_disp", 32'(ifB.inDisplayArea), 32'd1);
    repeat (7) @(negedge clk);
    check("b_x7",      32'(ifB.CounterX), 32'd7);
    check("b_disp_x7", 32'(ifB.inDisplayArea), 32'd1);
    @(negedge clk);
    check("b_disp_x8", 32'(ifB.inDisplayArea), 32'd0);
    repeat (55) @(negedge clk);
    check("b_x15_y3",  32'({ifB.CounterY, ifB.CounterX}), 32'({10'd3, 10'd15}));
    check("b_disp_15_3", 32'(ifB.inDisplayArea), 32'd0);
    @(negedge clk);
    check("b_x0_y4",   32'({ifB.CounterY, ifB.CounterX}), 32'({10'd4, 10'd0}));
    check("b_disp_0_4", 32'(ifB.inDisplayArea), 32'd0);
    repeat (79) @(negedge clk);
    check("b_last_pos", 32'({ifB.CounterY, ifB.CounterX}), 32'({10'd8, 10'd15}));
    check("b_last_fs",  32'(ifB.frame_start), 32'd0);
    check("b_last_fc",  32'(ifB.frame_count), 32'd0);
    @(negedge clk);
    check("b_wrap_pos", 32'({ifB.CounterY, ifB.CounterX}), 32'd0);
    check("b_wrap_fs",  32'(ifB.frame_start), 32'd1);
    check("b_wrap_fc",  32'(ifB.frame_count), 32'd1);

    prevS = ifB.vga_v_sync; prevH = ifB.vga_h_sync; nFall = 0; fallCyc = 0;
    period = -1; width = -1; lowRun = 0; nFs = 0; riseX = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ifB.frame_start) nFs++;
      if (!prevH && ifB.vga_h_sync && riseX < 0) riseX = int'(ifB.CounterX);
      if (!prevS && ifB.vga_v_sync) begin
        nFall++;
        if (nFall == 1) fallCyc = i;
        else if (nFall == 2) period = i - fallCyc;
      end
      if (ifB.vga_v_sync) lowRun++;
      else begin
        if (prevS && nFall > 0 && width < 0) width = lowRun;
        lowRun = 0;
      end
      prevS = ifB.vga_v_sync;
      prevH = ifB.vga_h_sync;
    end
    check("b_hs_rise_x", 32'(riseX), 32'd10);
    check("b_vs_width",  32'(width), 32'd32);
    check("b_vs_period", 32'(period), 32'd144);
    check("b_fs_pulses", 32'(nFs), 32'd2);
    check("b_run_fc",    32'(ifB.frame_count), 32'd3);
    check("b_run_x",     32'(ifB.CounterX), 32'd12);

    // Asynchronous reset in the middle of the vsync pulse.
    repeat (71) @(negedge clk);
    check("b_pre_pos", 32'({ifB.CounterY, ifB.CounterX}), 32'({10'd5, 10'd3}));
    check("b_pre_vs",  32'(ifB.vga_v_sync), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_pos",  32'({ifB.CounterY, ifB.CounterX}), 32'd0);
    check("arst_vs",   32'(ifB.vga_v_sync), 32'd0);
    check("arst_fc",   32'(ifB.frame_count), 32'd0);
    check("arst_disp", 32'(ifB.inDisplayArea), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("restart_pos", 32'({ifB.CounterY, ifB.CounterX}), 32'd0);
    check("restart_fs",  32'(ifB.frame_start), 32'd1);
    check("restart_fc",  32'(ifB.frame_count), 32'd0);

    // Frame counter preloaded to its maximum wraps to zero on the next frame.
    repeat (10) @(negedge clk);
    force ifB.frame_count = 16'hFFFF;
    @(negedge clk);
    release ifB.frame_count;
    check("pre_fc", 32'(ifB.frame_count), 32'd65535);
    repeat (132) @(negedge clk);
    check("pre_fc_hold", 32'(ifB.frame_count), 32'd65535);
    @(negedge clk);
    check("fc_wrap",    32'(ifB.frame_count), 32'd0);
    check("fc_wrap_fs", 32'(ifB.frame_start), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
